// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the execute result and runs an optional
// load/store over a req/ack handshake, guarded by a watchdog, before write-back.
module mem_stage #(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 4,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic [RADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0]  wdata_i,
    input  logic               we_i,
    input  logic [1:0]         memop_i,
    input  logic [DATA_W-1:0]  maddr_i,
    input  logic [DATA_W-1:0]  mdata_i,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [DATA_W-1:0]  mem_addr_o,
    output logic [DATA_W-1:0]  mem_wdata_o,
    input  logic [DATA_W-1:0]  mem_rdata_i,
    input  logic               mem_ack_i,
    output logic [RADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0]  wdata_o,
    output logic               we_o,
    output logic               stall_req_o,
    output logic               err_o
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic { IDLE, WAIT } state_t;
    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_RSVD  = 2'b11
    } memop_t;

    state_t             state_q;
    memop_t             op_in;
    logic               is_mem_op;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [RADDR_W-1:0] lat_waddr_q;
    logic               lat_we_q;
    logic               lat_load_q;
    logic               mem_req_q;
    logic               mem_we_q;
    logic [DATA_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_wdata_q;
    logic [RADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               we_q;
    logic               stall_req_q;
    logic               err_q;

    assign op_in     = memop_t'(memop_i);
    assign is_mem_op = (op_in == OP_LOAD) || (op_in == OP_STORE);
    assign cnt_d     = cnt_q + CNT_W'(1);

    // NOTE: every register here uses non-blocking assignment so all of them sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lat_waddr_q <= '0;
            lat_we_q    <= 1'b0;
            lat_load_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            stall_req_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (flush_i) begin
                        waddr_q <= '0;
                        wdata_q <= '0;
                        we_q    <= 1'b0;
                    end else if (!stall_i) begin
                        if (is_mem_op) begin
                            lat_waddr_q <= waddr_i;
                            lat_we_q    <= we_i;
                            lat_load_q  <= (op_in == OP_LOAD);
                            mem_addr_q  <= maddr_i;
                            mem_wdata_q <= mdata_i;
                            mem_we_q    <= (op_in == OP_STORE);
                            mem_req_q   <= 1'b1;
                            stall_req_q <= 1'b1;
                            waddr_q     <= '0;
                            wdata_q     <= '0;
                            we_q        <= 1'b0;
                            cnt_q       <= '0;
                            state_q     <= WAIT;
                        end else begin
                            waddr_q <= waddr_i;
                            wdata_q <= wdata_i;
                            we_q    <= we_i;
                        end
                    end
                end
                WAIT: begin
                    // Controller stall/flush are deliberately ignored: a started access always finishes.
                    if (mem_ack_i) begin
                        mem_req_q   <= 1'b0;
                        stall_req_q <= 1'b0;
                        waddr_q     <= lat_waddr_q;
                        wdata_q     <= lat_load_q ? mem_rdata_i : '0;
                        we_q        <= lat_we_q;
                        state_q     <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        mem_req_q   <= 1'b0;
                        stall_req_q <= 1'b0;
                        err_q       <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign waddr_o     = waddr_q;
    assign wdata_o     = wdata_q;
    assign we_o        = we_q;
    assign stall_req_o = stall_req_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic
// checked against a transaction-level model of the stage.
module tb_mem_stage;
    localparam int DATA_W  = 16;
    localparam int RADDR_W = 4;
    localparam int TIMEOUT = 4;

    typedef logic [RADDR_W+DATA_W:0]  wb_t;
    typedef logic [2*DATA_W+3:0]      mem_t;
    typedef logic [2:0]               ctl_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               stall_i, flush_i, we_i, mem_ack_i;
    logic [RADDR_W-1:0] waddr_i;
    logic [DATA_W-1:0]  wdata_i, maddr_i, mdata_i, mem_rdata_i;
    logic [1:0]         memop_i;
    logic               mem_req_o, mem_we_o, we_o, stall_req_o, err_o;
    logic [DATA_W-1:0]  mem_addr_o, mem_wdata_o, wdata_o;
    logic [RADDR_W-1:0] waddr_o;

    int checks = 0;
    int errors = 0;

    wb_t  wb_obs;
    mem_t mem_obs;
    ctl_t ctl_obs;
    wb_t  exp_wb;

    assign wb_obs  = {waddr_o, wdata_o, we_o};
    assign mem_obs = {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_req_o, err_o};
    assign ctl_obs = {mem_req_o, stall_req_o, err_o};

    always #5 clk = ~clk;

    mem_stage #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .waddr_i(waddr_i), .wdata_i(wdata_i), .we_i(we_i), .memop_i(memop_i),
        .maddr_i(maddr_i), .mdata_i(mdata_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .waddr_o(waddr_o), .wdata_o(wdata_o), .we_o(we_o),
        .stall_req_o(stall_req_o), .err_o(err_o)
    );

    function automatic wb_t wb_mk(input logic [RADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                  input logic w);
        return {a, d, w};
    endfunction

    function automatic mem_t mem_mk(input logic req, input logic st, input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] d, input logic stl, input logic e);
        return {req, st, a, d, stl, e};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fl, input logic st, input logic [RADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic w, input logic [1:0] op,
                         input logic [DATA_W-1:0] ma, input logic [DATA_W-1:0] md);
        flush_i = fl; stall_i = st; waddr_i = a; wdata_i = d; we_i = w;
        memop_i = op; maddr_i = ma; mdata_i = md;
    endtask

    task automatic drive_junk();
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), RADDR_W'($urandom),
              DATA_W'($urandom), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              DATA_W'($urandom), DATA_W'($urandom));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_junk();
        mem_ack_i = 1'b1; mem_rdata_i = 16'hFFFF;
        step();
        drive_junk();
        step();
        if (wb_obs !== '0) begin
            errors++; $display("FAIL reset_wb: got %h expected 0", wb_obs);
        end
        checks++;
        if (mem_obs !== '0) begin
            errors++; $display("FAIL reset_mem: got %h expected 0", mem_obs);
        end
        checks++;
        rst = 1'b0; mem_ack_i = 1'b0;
        drive(0, 0, '0, '0, 0, 2'b00, '0, '0);
    endtask

    task automatic test_alu();
        drive(0, 0, 4'd3, 16'h0233, 1'b1, 2'b00, 16'h5555, 16'h6666);
        step();
        if (wb_obs !== wb_mk(4'd3, 16'h0233, 1'b1)) begin
            errors++; $display("FAIL alu_wb: got %h expected %h", wb_obs, wb_mk(4'd3, 16'h0233, 1'b1));
        end
        checks++;
        if (ctl_obs !== 3'b000) begin
            errors++; $display("FAIL alu_ctl: got %b expected 000", ctl_obs);
        end
        checks++;
    endtask

    task automatic test_load();
        drive(0, 0, 4'd5, 16'h0AAA, 1'b1, 2'b01, 16'h1000, 16'h0C0C);
        step();
        drive(0, 0, '0, '0, 0, 2'b00, '0, '0);
        for (int c = 1; c <= 2; c++) begin
            if (mem_obs !== mem_mk(1, 0, 16'h1000, 16'h0C0C, 1, 0)) begin
                errors++; $display("FAIL load_wait%0d: got %h expected %h", c, mem_obs,
                                   mem_mk(1, 0, 16'h1000, 16'h0C0C, 1, 0));
            end
            checks++;
            if (wb_obs !== '0) begin
                errors++; $display("FAIL load_bubble%0d: got %h expected 0", c, wb_obs);
            end
            checks++;
            mem_ack_i = (c == 2); mem_rdata_i = (c == 2) ? 16'hBEEF : 16'h1111;
            step();
        end
        mem_ack_i = 1'b0;
        if (wb_obs !== wb_mk(4'd5, 16'hBEEF, 1'b1)) begin
            errors++; $display("FAIL load_result: got %h expected %h", wb_obs, wb_mk(4'd5, 16'hBEEF, 1'b1));
        end
        checks++;
        if (ctl_obs !== 3'b000) begin
            errors++; $display("FAIL load_done_ctl: got %b expected 000", ctl_obs);
        end
        checks++;
    endtask

    task automatic test_store();
        drive(0, 0, 4'd7, 16'h0F0F, 1'b0, 2'b10, 16'h0042, 16'h1234);
        step();
        drive(0, 0, '0, '0, 0, 2'b00, '0, '0);
        if (mem_obs !== mem_mk(1, 1, 16'h0042, 16'h1234, 1, 0)) begin
            errors++; $display("FAIL store_wait: got %h expected %h", mem_obs,
                               mem_mk(1, 1, 16'h0042, 16'h1234, 1, 0));
        end
        checks++;
        mem_ack_i = 1'b1; mem_rdata_i = 16'hAAAA;
        step();
        mem_ack_i = 1'b0;
        if (wb_obs !== wb_mk(4'd7, 16'h0000, 1'b0)) begin
            errors++; $display("FAIL store_result: got %h expected %h", wb_obs, wb_mk(4'd7, 16'h0000, 1'b0));
        end
        checks++;
        if (ctl_obs !== 3'b000) begin
            errors++; $display("FAIL store_ctl: got %b expected 000", ctl_obs);
        end
        checks++;
    endtask

    task automatic test_flush_stall();
        drive(0, 0, 4'd9, 16'h5A5A, 1'b1, 2'b00, '0, '0);
        step();
        drive(0, 1, 4'd2, 16'h0001, 1'b1, 2'b01, 16'h0777, '0);
        step();
        if (wb_obs !== wb_mk(4'd9, 16'h5A5A, 1'b1) || ctl_obs !== 3'b000) begin
            errors++; $display("FAIL idle_stall: got %h/%b expected %h/000", wb_obs, ctl_obs,
                               wb_mk(4'd9, 16'h5A5A, 1'b1));
        end
        checks++;
        drive(1, 1, 4'd2, 16'h0001, 1'b1, 2'b01, 16'h0777, '0);
        step();
        if (wb_obs !== '0 || ctl_obs !== 3'b000) begin
            errors++; $display("FAIL idle_flush: got %h/%b expected 0/000", wb_obs, ctl_obs);
        end
        checks++;
        drive(0, 0, 4'd4, 16'h0BBB, 1'b1, 2'b01, 16'h0300, 16'h0044);
        step();
        drive(1, 1, 4'd1, 16'h0001, 1'b1, 2'b00, '0, '0);
        for (int c = 1; c <= 2; c++) begin
            if (mem_obs !== mem_mk(1, 0, 16'h0300, 16'h0044, 1, 0)) begin
                errors++; $display("FAIL wait_flush%0d: got %h expected %h", c, mem_obs,
                                   mem_mk(1, 0, 16'h0300, 16'h0044, 1, 0));
            end
            checks++;
            mem_ack_i = (c == 2); mem_rdata_i = 16'h7777;
            step();
        end
        mem_ack_i = 1'b0;
        drive(0, 0, '0, '0, 0, 2'b00, '0, '0);
        if (wb_obs !== wb_mk(4'd4, 16'h7777, 1'b1)) begin
            errors++; $display("FAIL wait_flush_result: got %h expected %h", wb_obs,
                               wb_mk(4'd4, 16'h7777, 1'b1));
        end
        checks++;
    endtask

    task automatic test_timeout();
        drive(0, 0, 4'd6, 16'h0123, 1'b1, 2'b01, 16'h0BAD, 16'h0000);
        step();
        drive(0, 0, '0, '0, 0, 2'b00, '0, '0);
        mem_ack_i = 1'b0;
        for (int c = 1; c <= TIMEOUT; c++) begin
            if (mem_obs !== mem_mk(1, 0, 16'h0BAD, 16'h0000, 1, 0)) begin
                errors++; $display("FAIL timeout_wait%0d: got %h expected %h", c, mem_obs,
                                   mem_mk(1, 0, 16'h0BAD, 16'h0000, 1, 0));
            end
            checks++;
            step();
        end
        if (ctl_obs !== 3'b001 || wb_obs !== '0) begin
            errors++; $display("FAIL timeout_abort: got %b/%h expected 001/0", ctl_obs, wb_obs);
        end
        checks++;
        drive(0, 0, 4'd1, 16'h0101, 1'b1, 2'b00, '0, '0);
        step();
        if (ctl_obs !== 3'b000 || wb_obs !== wb_mk(4'd1, 16'h0101, 1'b1)) begin
            errors++; $display("FAIL timeout_after: got %b/%h expected 000/%h", ctl_obs, wb_obs,
                               wb_mk(4'd1, 16'h0101, 1'b1));
        end
        checks++;
    endtask

    task automatic test_reset_in_wait();
        drive(0, 0, 4'd8, 16'h0999, 1'b1, 2'b01, 16'h0123, 16'h0456);
        step();
        drive(0, 0, '0, '0, 0, 2'b00, '0, '0);
        step();
        if (ctl_obs !== 3'b110) begin
            errors++; $display("FAIL rstwait_pre: got %b expected 110", ctl_obs);
        end
        checks++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        if (mem_obs !== '0 || wb_obs !== '0) begin
            errors++; $display("FAIL rstwait_clear: got %h/%h expected 0/0", mem_obs, wb_obs);
        end
        checks++;
        mem_ack_i = 1'b1; mem_rdata_i = 16'hFFFF;
        step();
        mem_ack_i = 1'b0;
        if (ctl_obs !== 3'b000 || wb_obs !== '0) begin
            errors++; $display("FAIL rstwait_late_ack: got %b/%h expected 000/0", ctl_obs, wb_obs);
        end
        checks++;
    endtask

    // Transaction-level model: each instruction's effect on write-back and the
    // memory port is predicted from its kind and the randomly chosen ack delay.
    task automatic test_random();
        logic [RADDR_W-1:0] a;
        logic [DATA_W-1:0]  d, ma, md, rd;
        logic               w;
        logic [1:0]         op;
        logic               exp_err;
        int                 kind, k, nw;
        exp_wb = '0;
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 9);
            a  = RADDR_W'($urandom); d  = DATA_W'($urandom); w = 1'($urandom_range(0, 1));
            ma = DATA_W'($urandom);  md = DATA_W'($urandom); rd = DATA_W'($urandom);
            mem_ack_i = 1'($urandom_range(0, 1)); mem_rdata_i = DATA_W'($urandom);
            if (kind <= 4) begin
                op = 2'($urandom_range(0, 3));
                if (kind == 0) begin
                    drive(1, 1'($urandom_range(0, 1)), a, d, w, op, ma, md);
                    exp_wb = '0;
                end else if (kind == 1) begin
                    drive(0, 1, a, d, w, op, ma, md);
                end else begin
                    op = $urandom_range(0, 1) ? 2'b00 : 2'b11;
                    drive(0, 0, a, d, w, op, ma, md);
                    exp_wb = wb_mk(a, d, w);
                end
                step();
                if (wb_obs !== exp_wb || ctl_obs !== 3'b000) begin
                    errors++; $display("FAIL rand%0d_kind%0d: got %h/%b expected %h/000",
                                       n, kind, wb_obs, ctl_obs, exp_wb);
                end
                checks++;
            end else begin
                op = $urandom_range(0, 1) ? 2'b01 : 2'b10;
                k  = $urandom_range(1, TIMEOUT + 1);
                nw = (k > TIMEOUT) ? TIMEOUT : k;
                drive(0, 0, a, d, w, op, ma, md);
                step();
                for (int c = 1; c <= nw; c++) begin
                    if (mem_obs !== mem_mk(1, op == 2'b10, ma, md, 1, 0) || wb_obs !== '0) begin
                        errors++; $display("FAIL rand%0d_wait%0d: got %h/%h expected %h/0", n, c,
                                           mem_obs, wb_obs, mem_mk(1, op == 2'b10, ma, md, 1, 0));
                    end
                    checks++;
                    drive_junk();
                    mem_ack_i   = (c == k);
                    mem_rdata_i = (c == k) ? rd : DATA_W'($urandom);
                    step();
                end
                mem_ack_i = 1'b0;
                if (k <= TIMEOUT) begin
                    exp_wb  = wb_mk(a, (op == 2'b01) ? rd : '0, w);
                    exp_err = 1'b0;
                end else begin
                    exp_wb  = '0;
                    exp_err = 1'b1;
                end
                if (wb_obs !== exp_wb || ctl_obs !== {2'b00, exp_err}) begin
                    errors++; $display("FAIL rand%0d_done: got %h/%b expected %h/00%b",
                                       n, wb_obs, ctl_obs, exp_wb, exp_err);
                end
                checks++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        drive(0, 0, '0, '0, 0, 2'b00, '0, '0);
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_flush_stall();
        test_timeout();
        test_reset_in_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage directly downstream of the execute stage. Registers the execute result (destination address, data, write enable) together with an optional load/store request, runs that request against a single-port data memory through a req/ack handshake, and presents the final register write to write-back. While a memory access is outstanding it raises a stall request to the pipeline controller and emits bubbles. A watchdog aborts accesses that are never acknowledged.

## Interface
- `DATA_W`, 16, data and memory address width
- `RADDR_W`, 4, register address width
- `TIMEOUT`, 255, maximum cycles to wait for `mem_ack_i` before aborting (≥1)

- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `stall_i`  in  1  controller hold: keep the captured instruction, do not accept new input
- `flush_i`  in  1  controller flush: replace the captured instruction with a bubble
- `waddr_i`  in  RADDR_W  destination register from execute
- `wdata_i`  in  DATA_W  ALU result from execute
- `we_i`  in  1  register write enable from execute
- `memop_i`  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
- `maddr_i`  in  DATA_W  memory word address
- `mdata_i`  in  DATA_W  store data
- `mem_req_o`  out  1  memory request, held high until acknowledged
- `mem_we_o`  out  1  1 = store, 0 = load; valid while `mem_req_o`
- `mem_addr_o`  out  DATA_W  memory address; valid while `mem_req_o`
- `mem_wdata_o`  out  DATA_W  store data; valid while `mem_req_o`
- `mem_rdata_i`  in  DATA_W  load data, valid in the cycle `mem_ack_i` is high
- `mem_ack_i`  in  1  memory completion strobe
- `waddr_o`  out  RADDR_W  destination register to write-back
- `wdata_o`  out  DATA_W  write data to write-back
- `we_o`  out  1  register write enable to write-back
- `stall_req_o`  out  1  registered stall request to controller
- `err_o`  out  1  one-cycle pulse on watchdog abort

## Operation
- States: IDLE, WAIT.
- Reset: state IDLE; `waddr_o`, `wdata_o`, `we_o`, `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `stall_req_o`, `err_o`, watchdog counter all 0.
- IDLE, priority flush > stall > capture:
  - `flush_i`: outputs become bubble (`waddr_o`=0, `wdata_o`=0, `we_o`=0); stay IDLE.
  - `stall_i`: all outputs hold; inputs ignored.
  - memop none/reserved: `waddr_o`←`waddr_i`, `wdata_o`←`wdata_i`, `we_o`←`we_i`; stay IDLE.
  - memop load/store: latch `waddr_i`, `we_i`, op; drive `mem_addr_o`←`maddr_i`, `mem_wdata_o`←`mdata_i`, `mem_we_o`←(op==store), `mem_req_o`←1, `stall_req_o`←1; outputs to write-back become bubble; counter←0; go WAIT.
- WAIT: `stall_i` and `flush_i` ignored (a started access is never cancelled); memory outputs held stable.
  - `mem_ack_i`=1: `mem_req_o`←0, `stall_req_o`←0; `waddr_o`←latched addr, `we_o`←latched we; `wdata_o`←`mem_rdata_i` for load, 0 for store; go IDLE.
  - no ack, counter == TIMEOUT−1: abort: `mem_req_o`←0, `stall_req_o`←0, bubble to write-back, `err_o`←1 for one cycle; go IDLE.
  - otherwise counter increments; bubble held.
- `err_o` is 0 in every cycle other than the one following an abort.
- Ack while `mem_req_o` is 0 is ignored.

## Timing
- Non-memory instruction: result at outputs one cycle after capture edge.
- Memory instruction with ack in the k-th WAIT cycle (k≥1): `mem_req_o` high for k cycles; result at outputs after edge k+1 following capture; `stall_req_o` high exactly k cycles.
- `stall_req_o` is registered; controller sees it the cycle after capture and must hold upstream until it falls.
- Rising edge with `rst`=1 overrides everything, including a WAIT in progress: request drops, state IDLE, outputs zero.
- Watchdog: abort after exactly TIMEOUT WAIT cycles without ack.

## Test plan
- Reset then ALU op: waddr 3, wdata 0x0233, we 1, memop 00 -> next cycle waddr_o 3, wdata_o 0x0233, we_o 1, mem_req_o 0.
- Load: waddr 5, maddr 0x1000, ack with rdata 0xBEEF after 2 cycles -> mem_req_o/stall_req_o high 2 cycles, mem_addr_o 0x1000, mem_we_o 0, then waddr_o 5, wdata_o 0xBEEF, we_o 1.
- Store: maddr 0x0042, mdata 0x1234, we 0, ack after 1 cycle -> mem_we_o 1, mem_wdata_o 0x1234, then we_o 0, no err.
- Flush and stall in IDLE, then flush during WAIT -> IDLE flush yields bubble, stall holds previous outputs, WAIT flush ignored and load still completes.
- TIMEOUT=4, no ack -> mem_req_o high 4 cycles, then err_o pulses 1 cycle, we_o 0, state IDLE, next ALU op passes normally.
- rst asserted in 2nd WAIT cycle -> next cycle mem_req_o 0, stall_req_o 0, all outputs 0; a later ack is ignored.
